fetch_unit: RTL and testbench

Instruction fetch stage that owns the program counter. It issues single-outstanding requests to instruction memory and presents fetched instructions to decode over a valid/ready handshake. It applies redirects from the downstream branch resolution logic (branch_valid/taken/target) and discards in-flight fetches made stale by a redirect. One fetch in flight at a time, suited to the multicycle RV32I core.

---
 rtl/fetch_unit.sv | 121 ++++++++++++
 tb/tb_fetch_unit.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, keeps at most one imem request outstanding,
// and hands fetched words to decode. Applies branch redirects and drops stale responses.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        branch_valid,
  input  logic        taken,
  input  logic [31:0] target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_pc,
  output logic [31:0] if_instr,
  output logic        fault
);

  // Handshakes: a transfer happens on a rising edge where valid&ready are both 1;
  // the producer holds valid and its payload stable until that edge.
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_REQ   = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_HOLD  = 3'd3;
  localparam logic [2:0] S_DROP  = 3'd4;
  localparam logic [2:0] S_FAULT = 3'd5;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic [2:0]  state;
  logic [31:0] pc;
  logic        drop_pend;
  logic        fault_req;
  logic        redirect;
  logic        bad_target;

  assign redirect   = branch_valid & taken & (target[1:0] == 2'b00);
  assign bad_target = branch_valid & taken & (target[1:0] != 2'b00);

  // A request raised before a fault must still complete its handshake.
  assign imem_req = (state == S_REQ) | ((state == S_FAULT) & fault_req);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      pc        <= RESET_PC;
      imem_addr <= RESET_PC;
      if_valid  <= 1'b0;
      if_pc     <= 32'h0000_0000;
      if_instr  <= NOP;
      fault     <= 1'b0;
      drop_pend <= 1'b0;
      fault_req <= 1'b0;
    end else if (bad_target && state != S_FAULT) begin
      fault     <= 1'b1;
      if_valid  <= 1'b0;
      state     <= S_FAULT;
      drop_pend <= 1'b0;
      fault_req <= (state == S_REQ) && !imem_ready;
    end else begin
      if (redirect && state != S_FAULT) pc <= target;
      case (state)
        S_IDLE: begin
          imem_addr <= redirect ? target : pc;
          state     <= S_REQ;
        end
        S_REQ: begin
          // imem_addr must not move while the request is pending; remember the redirect instead.
          if (imem_ready) begin
            state     <= (redirect || drop_pend) ? S_DROP : S_WAIT;
            drop_pend <= 1'b0;
          end else if (redirect) begin
            drop_pend <= 1'b1;
          end
        end
        S_WAIT: begin
          if (imem_rvalid) begin
            if (redirect) begin
              imem_addr <= target;
              state     <= S_REQ;
            end else begin
              if_instr <= imem_rdata;
              if_pc    <= imem_addr;
              if_valid <= 1'b1;
              pc       <= imem_addr + 32'd4;
              state    <= S_HOLD;
            end
          end else if (redirect) begin
            state <= S_DROP;
          end
        end
        S_HOLD: begin
          if (redirect) begin
            if_valid  <= 1'b0;
            imem_addr <= target;
            state     <= S_REQ;
          end else if (if_ready) begin
            if_valid  <= 1'b0;
            imem_addr <= pc;
            state     <= S_REQ;
          end
        end
        S_DROP: begin
          if (imem_rvalid) begin
            imem_addr <= redirect ? target : pc;
            state     <= S_REQ;
          end
        end
        S_FAULT: begin
          if (imem_ready) fault_req <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a latency-programmable memory responder returns addr^0xAA,
// and a linear sequence of steps checks every observation with immediate assertions.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        branch_valid;
  logic        taken;
  logic [31:0] target;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
  logic        fault;

  int checks = 0;
  int errors = 0;

  // Memory responder state; lat = cycles from acceptance to rvalid.
  int          lat = 1;
  int          cnt = 0;
  bit          pend = 1'b0;
  logic [31:0] pend_addr = 32'h0;

  fetch_unit #(.RESET_PC(32'h0000_0100)) dut (
    .clk          (clk),
    .rst          (rst),
    .branch_valid (branch_valid),
    .taken        (taken),
    .target       (target),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ready   (imem_ready),
    .imem_rvalid  (imem_rvalid),
    .imem_rdata   (imem_rdata),
    .if_valid     (if_valid),
    .if_ready     (if_ready),
    .if_pc        (if_pc),
    .if_instr     (if_instr),
    .fault        (fault)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (imem_rvalid) pend = 1'b0;
    if (imem_req && imem_ready) begin
      pend      = 1'b1;
      pend_addr = imem_addr;
      cnt       = lat;
    end
    #2;
    if (pend && cnt > 0) cnt--;
    imem_rvalid = pend && (cnt == 0);
    imem_rdata  = imem_rvalid ? (pend_addr ^ 32'h0000_00AA) : 32'hDEAD_BEEF;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic set_branch(input logic v, input logic t, input logic [31:0] a);
    branch_valid = v;
    taken        = t;
    target       = a;
  endtask

  task automatic expect_fetch(input logic [31:0] epc, input logic [31:0] ei);
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (!if_valid && n < 20);
    chk("fetch_valid", {31'b0, if_valid}, 32'd1);
    chk("fetch_pc", if_pc, epc);
    chk("fetch_instr", if_instr, ei);
  endtask

  task automatic chk_reset_values();
    chk("rst_req", {31'b0, imem_req}, 32'd0);
    chk("rst_addr", imem_addr, 32'h0000_0100);
    chk("rst_if_valid", {31'b0, if_valid}, 32'd0);
    chk("rst_if_pc", if_pc, 32'h0);
    chk("rst_if_instr", if_instr, 32'h0000_0013);
    chk("rst_fault", {31'b0, fault}, 32'd0);
  endtask

  initial begin
    int seen;
    rst        = 1'b1;
    imem_ready = 1'b1;
    if_ready   = 1'b1;
    set_branch(1'b0, 1'b0, 32'h0);
    repeat (2) tick();
    chk_reset_values();
    rst = 1'b0;

    // Zero-wait fetch of 0x100: REQ, WAIT, HOLD on consecutive cycles.
    tick();
    chk("req_100", {31'b0, imem_req}, 32'd1);
    chk("addr_100", imem_addr, 32'h100);
    tick();
    chk("wait_no_req", {31'b0, imem_req}, 32'd0);
    tick();
    chk("hold_valid", {31'b0, if_valid}, 32'd1);
    chk("hold_pc", if_pc, 32'h100);
    chk("hold_instr", if_instr, 32'h1AA);
    tick();
    chk("req_104", {31'b0, imem_req}, 32'd1);
    chk("addr_104", imem_addr, 32'h104);
    chk("valid_dropped", {31'b0, if_valid}, 32'd0);

    // Memory stalls four cycles: request and address hold steady.
    imem_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("stall_req", {31'b0, imem_req}, 32'd1);
      chk("stall_addr", imem_addr, 32'h104);
    end
    imem_ready = 1'b1;
    expect_fetch(32'h104, 32'h1AE);
    expect_fetch(32'h108, 32'h1A2);

    // Redirect while waiting on a slow response; the 0x10C data must be discarded.
    lat = 3;
    tick();
    chk("req_10c", imem_addr, 32'h10C);
    tick();
    set_branch(1'b1, 1'b1, 32'h200);
    tick();
    set_branch(1'b0, 1'b0, 32'h0);
    chk("drop_no_valid", {31'b0, if_valid}, 32'd0);
    chk("drop_no_req", {31'b0, imem_req}, 32'd0);
    tick();
    chk("stale_rvalid_seen", {31'b0, imem_rvalid}, 32'd1);
    chk("stale_not_shown", {31'b0, if_valid}, 32'd0);
    lat = 1;
    expect_fetch(32'h200, 32'h2AA);

    // Redirect in HOLD with if_ready=1 flushes the held instruction.
    set_branch(1'b1, 1'b1, 32'h300);
    tick();
    set_branch(1'b0, 1'b0, 32'h0);
    chk("flush_valid", {31'b0, if_valid}, 32'd0);
    chk("flush_addr", imem_addr, 32'h300);
    expect_fetch(32'h300, 32'h3AA);

    // Not-taken branch held across a whole fetch changes nothing.
    set_branch(1'b1, 1'b0, 32'h500);
    expect_fetch(32'h304, 32'h3AE);
    set_branch(1'b0, 1'b0, 32'h0);

    // PC wraps from 0xFFFF_FFFC to 0.
    set_branch(1'b1, 1'b1, 32'hFFFF_FFFC);
    tick();
    set_branch(1'b0, 1'b0, 32'h0);
    chk("wrap_addr", imem_addr, 32'hFFFF_FFFC);
    expect_fetch(32'hFFFF_FFFC, 32'hFFFF_FF56);
    expect_fetch(32'h0, 32'hAA);
    expect_fetch(32'h4, 32'hAE);

    // Misaligned taken target: sticky fault, no further requests.
    set_branch(1'b1, 1'b1, 32'h202);
    tick();
    set_branch(1'b0, 1'b0, 32'h0);
    chk("fault_set", {31'b0, fault}, 32'd1);
    chk("fault_no_valid", {31'b0, if_valid}, 32'd0);
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      if (imem_req || if_valid) seen++;
      tick();
    end
    chk("fault_quiet", seen, 32'd0);
    chk("fault_sticky", {31'b0, fault}, 32'd1);

    rst = 1'b1;
    tick();
    chk_reset_values();
    rst = 1'b0;
    expect_fetch(32'h100, 32'h1AA);

    // Reset in WAIT with the response arriving just after; that response is ignored.
    lat = 2;
    tick();
    chk("pre_rst_addr", imem_addr, 32'h104);
    tick();
    chk("pre_rst_wait", {31'b0, imem_req}, 32'd0);
    rst = 1'b1;
    tick();
    chk_reset_values();
    rst = 1'b0;
    lat = 1;
    expect_fetch(32'h100, 32'h1AA);
    chk("post_rst_fault", {31'b0, fault}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
